cu8_rr_arbiter: RTL and testbench

- Shares one EightDataCompressUnit between NREQ requesters.
- Accepts 8x32-bit bundles from requesters under round-robin arbitration and drives the unit's validIn/wrtEn/dataIn.
- Tracks the requester ID of every in-flight bundle in an in-order ID FIFO, then routes each compressed result (dataOut/tagOut/lenOut) back to its owner.
- Sits between the per-lane input buffers and the shared compress unit.

---
 rtl/cu8_rr_arbiter_if.sv | 42 ++++
 rtl/cu8_rr_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_cu8_rr_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cu8_rr_arbiter_if.sv
// Requester and compress-unit bus for cu8_rr_arbiter.
// slave  : arbiter side (accepts bundles, drives the compress unit, returns results)
// master : environment side (requesters plus the compress unit model)
interface cu8_rr_arbiter_if #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]     reqValid;
    logic [NREQ*256-1:0] reqData;
    logic [NREQ-1:0]     reqReady;

    logic                cuValidIn;
    logic                cuWrtEn;
    logic [255:0]        cuDataIn;

    logic                cuValidOut;
    logic [255:0]        cuDataOut;
    logic [15:0]         cuTagOut;
    logic [7:0]          cuLenOut;

    logic [NREQ-1:0]     rspValid;
    logic [255:0]        rspData;
    logic [15:0]         rspTag;
    logic [7:0]          rspLen;
    logic [IDW-1:0]      rspId;

    modport slave (
        input  reqValid, reqData,
        input  cuValidOut, cuDataOut, cuTagOut, cuLenOut,
        output reqReady,
        output cuValidIn, cuWrtEn, cuDataIn,
        output rspValid, rspData, rspTag, rspLen, rspId
    );

    modport master (
        output reqValid, reqData,
        output cuValidOut, cuDataOut, cuTagOut, cuLenOut,
        input  reqReady,
        input  cuValidIn, cuWrtEn, cuDataIn,
        input  rspValid, rspData, rspTag, rspLen, rspId
    );
endinterface

// File: rtl/cu8_rr_arbiter.sv
// Round-robin arbiter sharing one EightDataCompressUnit between NREQ requesters.
// Requester IDs of in-flight bundles are kept in an in-order FIFO so every
// compressed result is routed back to the requester that issued it.
// Optional build macro CU8_ARB_STATS_EN adds per-requester compressed-byte
// counters (statClear input, statBytes output).
module cu8_rr_arbiter #(
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int MAX_OUT = 8,
    parameter int CNTW    = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    cu8_rr_arbiter_if.slave      bus,
`ifdef CU8_ARB_STATS_EN
    input  logic                 statClear,
    output logic [NREQ*32-1:0]   statBytes,
`endif
    output logic                 busy,
    output logic                 ovfErr
);

    localparam int PTRW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

    logic [IDW-1:0]  rrPtr;
    logic [CNTW-1:0] outstanding;
    logic [PTRW-1:0] wrPtr;
    logic [PTRW-1:0] rdPtr;
    logic [IDW-1:0]  idFifo [MAX_OUT];

    logic            grantFound;
    logic [IDW-1:0]  grantId;
    logic [NREQ-1:0] grantVec;
    logic [255:0]    winData;
    logic            canGrant;
    logic            accept;
    logic            pop;
    logic [IDW-1:0]  popId;

    // The full check uses the registered count only, so a pop in the same
    // cycle does not reopen the grant until the following cycle.
    assign canGrant = !reset && enable && (outstanding < CNTW'(MAX_OUT));

    // Round-robin search starting one position past the last winner
    always_comb begin : rrSearch
        logic [IDW-1:0] cand;
        grantFound = 1'b0;
        grantId    = '0;
        cand       = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IDW'((int'(rrPtr) + k) % NREQ);
            if (!grantFound && bus.reqValid[cand]) begin
                grantFound = 1'b1;
                grantId    = cand;
            end
        end
    end

    assign grantVec     = (canGrant && grantFound) ? (NREQ'(1) << grantId) : '0;
    assign bus.reqReady = grantVec;
    assign accept       = |(grantVec & bus.reqValid);

    // Select the winner's bundle from the one-hot grant
    always_comb begin
        winData = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grantVec[i]) begin
                winData = bus.reqData[i*256 +: 256];
            end
        end
    end

    // A result is only routed when something is in flight; otherwise it is spurious
    assign pop   = bus.cuValidOut && (outstanding != '0);
    assign popId = idFifo[rdPtr];
    assign busy  = (outstanding != '0);

    // Issue path: forward the accepted bundle and remember the winner
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.cuValidIn <= 1'b0;
            bus.cuWrtEn   <= 1'b0;
            bus.cuDataIn  <= '0;
            rrPtr         <= IDW'(NREQ - 1);
        end else begin
            bus.cuValidIn <= accept;
            bus.cuWrtEn   <= accept;
            if (accept) begin
                bus.cuDataIn <= winData;
                rrPtr        <= grantId;
            end
        end
    end

    // ID FIFO storage; entries are only read behind a valid write so no reset is needed
    always_ff @(posedge clk) begin
        if (accept) begin
            idFifo[wrPtr] <= grantId;
        end
    end

    // ID FIFO pointers, wrapping modulo the (power of two) depth
    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (accept) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (pop) begin
                rdPtr <= rdPtr + 1'b1;
            end
        end
    end

    // In-flight bundle count
    always_ff @(posedge clk) begin
        if (reset) begin
            outstanding <= '0;
        end else begin
            case ({accept, pop})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    // Response path: route the result to the FIFO-head owner
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.rspValid <= '0;
            bus.rspData  <= '0;
            bus.rspTag   <= '0;
            bus.rspLen   <= '0;
            bus.rspId    <= '0;
        end else if (pop) begin
            bus.rspValid <= NREQ'(1) << popId;
            bus.rspId    <= popId;
            bus.rspData  <= bus.cuDataOut;
            bus.rspTag   <= bus.cuTagOut;
            bus.rspLen   <= bus.cuLenOut;
        end else begin
            bus.rspValid <= '0;
        end
    end

    // Sticky flag for a result arriving with nothing in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            ovfErr <= 1'b0;
        end else if (bus.cuValidOut && (outstanding == '0)) begin
            ovfErr <= 1'b1;
        end
    end

`ifdef CU8_ARB_STATS_EN
    logic [31:0] statCnt [NREQ];
    logic [32:0] statSum;

    assign statSum = {1'b0, statCnt[popId]} + 33'(bus.cuLenOut);

    // Saturating per-requester byte counters; clear beats a same-cycle add
    always_ff @(posedge clk) begin
        if (reset || statClear) begin
            for (int i = 0; i < NREQ; i++) begin
                statCnt[i] <= '0;
            end
        end else if (pop) begin
            statCnt[popId] <= statSum[32] ? 32'hFFFF_FFFF : statSum[31:0];
        end
    end

    // Flatten the counters onto the output bus
    always_comb begin
        statBytes = '0;
        for (int i = 0; i < NREQ; i++) begin
            statBytes[i*32 +: 32] = statCnt[i];
        end
    end
`endif

endmodule

// File: tb/tb_cu8_rr_arbiter.sv
// Self-checking bench for cu8_rr_arbiter: directed vector table, hand-written
// corner sequences and a randomized run against a queue-based reference model.
module tb_cu8_rr_arbiter;
    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int MAXO = 8;

    logic clk = 1'b0;
    logic reset;
    logic enable;
    logic busy;
    logic ovfErr;
`ifdef CU8_ARB_STATS_EN
    logic                 statClear;
    logic [NREQ*32-1:0]   statBytes;
`endif

    cu8_rr_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

    cu8_rr_arbiter #(.NREQ(NREQ), .IDW(IDW), .MAX_OUT(MAXO), .CNTW(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .bus       (bus),
`ifdef CU8_ARB_STATS_EN
        .statClear (statClear),
        .statBytes (statBytes),
`endif
        .busy      (busy),
        .ovfErr    (ovfErr)
    );

    always #5 clk = ~clk;

    int nChecks;
    int nFail;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int              mq[$];
    int              mRr;
    logic            mKnown;
    logic            eCuValid;
    logic [255:0]    eCuData;
    logic [NREQ-1:0] eRspValid;
    logic [IDW-1:0]  eRspId;
    logic [255:0]    eRspData;
    logic [15:0]     eRspTag;
    logic [7:0]      eRspLen;
    logic            eOvf;
    longint          mStat[NREQ];

    task automatic checkRegs();
        chk("cuValidIn", 256'(bus.cuValidIn), 256'(eCuValid));
        chk("cuWrtEn",   256'(bus.cuWrtEn),   256'(eCuValid));
        chk("cuDataIn",  bus.cuDataIn,        eCuData);
        chk("rspValid",  256'(bus.rspValid),  256'(eRspValid));
        chk("rspId",     256'(bus.rspId),     256'(eRspId));
        chk("rspData",   bus.rspData,         eRspData);
        chk("rspTag",    256'(bus.rspTag),    256'(eRspTag));
        chk("rspLen",    256'(bus.rspLen),    256'(eRspLen));
        chk("ovfErr",    256'(ovfErr),        256'(eOvf));
        chk("busy",      256'(busy),          256'(mq.size() != 0));
`ifdef CU8_ARB_STATS_EN
        for (int i = 0; i < NREQ; i++) begin
            chk($sformatf("statBytes%0d", i), 256'(statBytes[i*32 +: 32]), 256'(mStat[i]));
        end
`endif
    endtask

    task automatic modelStep();
        int win;
        logic [NREQ-1:0] expReady;
        logic clr;
        win = -1;
        expReady = '0;
        clr = 1'b0;
`ifdef CU8_ARB_STATS_EN
        clr = statClear;
`endif
        if (mKnown) checkRegs();
        if (!reset && enable && mq.size() < MAXO) begin
            for (int k = 1; k <= NREQ; k++) begin
                if (win < 0 && bus.reqValid[(mRr + k) % NREQ]) win = (mRr + k) % NREQ;
            end
        end
        if (win >= 0) expReady = NREQ'(1) << win;
        chk("reqReady", 256'(bus.reqReady), 256'(expReady));

        if (reset) begin
            mq.delete();
            mRr = NREQ - 1;
            eCuValid = 1'b0; eCuData = '0;
            eRspValid = '0; eRspId = '0; eRspData = '0; eRspTag = '0; eRspLen = '0;
            eOvf = 1'b0;
            for (int i = 0; i < NREQ; i++) mStat[i] = 0;
            mKnown = 1'b1;
        end else begin
            eRspValid = '0;
            if (bus.cuValidOut) begin
                if (mq.size() > 0) begin
                    int id;
                    id = mq.pop_front();
                    eRspValid = NREQ'(1) << id;
                    eRspId    = IDW'(id);
                    eRspData  = bus.cuDataOut;
                    eRspTag   = bus.cuTagOut;
                    eRspLen   = bus.cuLenOut;
                    mStat[id] = mStat[id] + longint'(bus.cuLenOut);
                    if (mStat[id] > 64'hFFFF_FFFF) mStat[id] = 64'hFFFF_FFFF;
                end else begin
                    eOvf = 1'b1;
                end
            end
            if (clr) begin
                for (int i = 0; i < NREQ; i++) mStat[i] = 0;
            end
            if (win >= 0) begin
                mq.push_back(win);
                mRr = win;
                eCuValid = 1'b1;
                eCuData  = bus.reqData[win*256 +: 256];
            end else begin
                eCuValid = 1'b0;
            end
        end
    endtask

    // One clock: settle inputs, check and update model, advance to next negedge
    task automatic step();
        #1;
        modelStep();
        @(negedge clk);
    endtask

    task automatic doReset();
        reset = 1'b1;
        bus.reqValid = '0;
        bus.cuValidOut = 1'b0;
        step();
        reset = 1'b0;
    endtask

    typedef struct packed {
        logic [NREQ-1:0] v;
        logic            cuv;
        logic [NREQ-1:0] expReady;
    } vec_t;
    vec_t vecs[12];

    logic [255:0] d1;
    int nAcc;

    initial begin
        nChecks = 0;
        nFail = 0;
        mKnown = 1'b0;
        mRr = NREQ - 1;
        reset = 1'b1;
        enable = 1'b1;
        bus.reqValid = '0;
        bus.reqData = '0;
        bus.cuValidOut = 1'b0;
        bus.cuDataOut = '0;
        bus.cuTagOut = '0;
        bus.cuLenOut = '0;
`ifdef CU8_ARB_STATS_EN
        statClear = 1'b0;
`endif
        @(negedge clk);

        // reset holds reqReady low even with requests pending
        bus.reqValid = 4'b1111;
        #1 chk("resetReady", 256'(bus.reqReady), 256'(0));
        step();
        doReset();
        chk("resetCuValid", 256'(bus.cuValidIn), 256'(0));
        chk("resetBusy", 256'(busy), 256'(0));

        // single bundle from requester 0
        d1 = 256'hFEDC_BA98_0000_7654_0000_0032_1FED_CBA9_0000_8765_0000_0043_0000_0000_0000_0021;
        bus.reqData[255:0] = d1;
        bus.reqValid = 4'b0001;
        #1 chk("t1Ready", 256'(bus.reqReady), 256'(4'b0001));
        step();
        bus.reqValid = '0;
        chk("t1CuValid", 256'(bus.cuValidIn), 256'(1));
        chk("t1CuData", bus.cuDataIn, d1);
        bus.cuValidOut = 1'b1;
        bus.cuLenOut = 8'h0F;
        bus.cuTagOut = 16'b1110011110010001;
        bus.cuDataOut = {8{32'hA5A5_0F0F}};
        step();
        bus.cuValidOut = 1'b0;
        chk("t1RspValid", 256'(bus.rspValid), 256'(4'b0001));
        chk("t1RspId", 256'(bus.rspId), 256'(0));
        chk("t1RspLen", 256'(bus.rspLen), 256'(8'h0F));
        chk("t1RspTag", 256'(bus.rspTag), 256'(16'b1110011110010001));
        step();

        // fairness table
        doReset();
        vecs[0] = '{4'b1111, 1'b0, 4'b0001};
        vecs[1] = '{4'b1111, 1'b1, 4'b0010};
        vecs[2] = '{4'b1111, 1'b1, 4'b0100};
        vecs[3] = '{4'b1111, 1'b1, 4'b1000};
        vecs[4] = '{4'b1111, 1'b1, 4'b0001};
        vecs[5] = '{4'b1111, 1'b1, 4'b0010};
        vecs[6] = '{4'b1111, 1'b1, 4'b0100};
        vecs[7] = '{4'b1111, 1'b1, 4'b1000};
        vecs[8] = '{4'b1010, 1'b1, 4'b0010};
        vecs[9] = '{4'b1010, 1'b1, 4'b1000};
        vecs[10] = '{4'b1010, 1'b1, 4'b0010};
        vecs[11] = '{4'b1010, 1'b1, 4'b1000};
        for (int i = 0; i < 12; i++) begin
            bus.reqValid = vecs[i].v;
            bus.cuValidOut = vecs[i].cuv;
            bus.cuLenOut = 8'(i);
            #1 chk($sformatf("vec%0dReady", i), 256'(bus.reqReady), 256'(vecs[i].expReady));
            step();
        end
        bus.reqValid = '0;
        bus.cuValidOut = 1'b1;
        step();
        bus.cuValidOut = 1'b0;
        step();

        // full stall: nine pending, only eight accepted
        doReset();
        bus.reqValid = 4'b1111;
        nAcc = 0;
        for (int i = 0; i < 10; i++) begin
            #1 if (|bus.reqReady) nAcc++;
            step();
        end
        chk("fullAccepts", 256'(nAcc), 256'(8));
        chk("fullBusy", 256'(busy), 256'(1));
        bus.cuValidOut = 1'b1;
        #1 chk("fullPopNoGrant", 256'(bus.reqReady), 256'(0));
        step();
        bus.cuValidOut = 1'b0;
        #1 chk("fullResume", 256'(bus.reqReady), 256'(4'b0001));
        step();
        bus.reqValid = '0;
        bus.cuValidOut = 1'b1;
        for (int i = 0; i < 9; i++) step();
        bus.cuValidOut = 1'b0;
        chk("fullDrained", 256'(busy), 256'(0));
        step();

        // simultaneous accept and pop at three in flight
        doReset();
        bus.reqValid = 4'b0100; step();
        bus.reqValid = 4'b0001; step();
        bus.reqValid = 4'b0010; step();
        bus.reqValid = 4'b1000;
        bus.cuValidOut = 1'b1;
        step();
        bus.reqValid = '0;
        chk("simRsp0", 256'(bus.rspId), 256'(2));
        step();
        chk("simRsp1", 256'(bus.rspId), 256'(0));
        step();
        chk("simRsp2", 256'(bus.rspId), 256'(1));
        step();
        chk("simRsp3", 256'(bus.rspId), 256'(3));
        bus.cuValidOut = 1'b0;
        chk("simDrained", 256'(busy), 256'(0));
        step();

        // spurious result right after reset
        doReset();
        bus.cuValidOut = 1'b1;
        step();
        bus.cuValidOut = 1'b0;
        chk("spurOvf", 256'(ovfErr), 256'(1));
        chk("spurRsp", 256'(bus.rspValid), 256'(0));
        step();
        step();
        chk("spurSticky", 256'(ovfErr), 256'(1));
        doReset();
        chk("spurCleared", 256'(ovfErr), 256'(0));

`ifdef CU8_ARB_STATS_EN
        // byte counters for requester 2
        bus.reqValid = 4'b0100;
        for (int i = 0; i < 4; i++) step();
        bus.reqValid = '0;
        bus.cuValidOut = 1'b1;
        bus.cuLenOut = 8'h0F; step();
        bus.cuLenOut = 8'h20; step();
        bus.cuLenOut = 8'h00; step();
        bus.cuValidOut = 1'b0;
        chk("statSum", 256'(statBytes[2*32 +: 32]), 256'(32'h2F));
        bus.cuValidOut = 1'b1;
        bus.cuLenOut = 8'h05;
        statClear = 1'b1;
        step();
        statClear = 1'b0;
        bus.cuValidOut = 1'b0;
        chk("statClearWins", 256'(statBytes[2*32 +: 32]), 256'(0));
        step();
`endif

        // randomized run against the model
        doReset();
        for (int c = 0; c < 600; c++) begin
            reset = ($urandom_range(0, 99) == 0);
            enable = ($urandom_range(0, 99) < 85);
            bus.reqValid = NREQ'($urandom());
            for (int w = 0; w < NREQ*8; w++) bus.reqData[w*32 +: 32] = $urandom();
            bus.cuValidOut = ($urandom_range(0, 99) < 45);
            for (int w = 0; w < 8; w++) bus.cuDataOut[w*32 +: 32] = $urandom();
            bus.cuTagOut = 16'($urandom());
            bus.cuLenOut = 8'($urandom_range(0, 32));
`ifdef CU8_ARB_STATS_EN
            statClear = ($urandom_range(0, 49) == 0);
`endif
            step();
        end
        reset = 1'b0;
        enable = 1'b1;
        bus.reqValid = '0;
        bus.cuValidOut = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", nChecks, nFail);
        $finish;
    end
endmodule
